// File: rtl/regfile_pkg.sv
// Shared constants and word type for the multi-port register file slice.
package regfile_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    typedef logic [DATA_W_DEF-1:0] rf_word_t;

endpackage

// File: rtl/regfile_fwd.sv
// Per-read-port output mux: write-through bypass from both write ports, then zero-register override.
module regfile_fwd
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              wen0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              wen1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              suppress,
    output logic [DATA_W-1:0] rdata
);

    // Port 1 wins over port 0 so the forwarded value matches what the edge will store.
    always_comb begin
        rdata = reg_data;
        if (BYPASS != 0 && !suppress) begin
            if (wen1 && waddr1 == raddr) begin
                rdata = wdata1;
            end else if (wen0 && waddr0 == raddr) begin
                rdata = wdata0;
            end
        end
        if (ZERO_REG != 0 && raddr == '0) begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Two-write, two-read register file with optional bypass, zero register and a one-deep checkpoint bank.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              WEN0,
    input  logic [ADDR_W-1:0] RW0,
    input  logic [DATA_W-1:0] busW0,
    input  logic              WEN1,
    input  logic [ADDR_W-1:0] RW1,
    input  logic [DATA_W-1:0] busW1,
    input  logic [ADDR_W-1:0] RX,
    input  logic [ADDR_W-1:0] RY,
    output logic [DATA_W-1:0] busX,
    output logic [DATA_W-1:0] busY,
    input  logic              CKPT,
    input  logic              RSTR,
    output logic              CkptV
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs   [DEPTH];
    logic [DATA_W-1:0] shadow [DEPTH];
    logic              ckpt_v;
    logic              restore;
    logic              wr0;
    logic              wr1;

    assign restore = RSTR && ckpt_v;
    assign wr0     = WEN0 && !(ZERO_REG != 0 && RW0 == '0);
    assign wr1     = WEN1 && !(ZERO_REG != 0 && RW1 == '0);
    assign CkptV   = ckpt_v;

    // A restore drops both writes and any checkpoint request of the same cycle.
    // Port 1 is assigned last so it wins an address collision.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i]   <= '0;
                shadow[i] <= '0;
            end
            ckpt_v <= 1'b0;
        end else if (restore) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= shadow[i];
            end
        end else begin
            if (CKPT) begin
                for (int i = 0; i < DEPTH; i++) begin
                    shadow[i] <= regs[i];
                end
                ckpt_v <= 1'b1;
            end
            if (wr0) begin
                regs[RW0] <= busW0;
            end
            if (wr1) begin
                regs[RW1] <= busW1;
            end
        end
    end

    regfile_fwd #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS),
        .ZERO_REG(ZERO_REG)
    ) fwd_x (
        .raddr   (RX),
        .reg_data(regs[RX]),
        .wen0    (WEN0),
        .waddr0  (RW0),
        .wdata0  (busW0),
        .wen1    (WEN1),
        .waddr1  (RW1),
        .wdata1  (busW1),
        .suppress(restore),
        .rdata   (busX)
    );

    regfile_fwd #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS),
        .ZERO_REG(ZERO_REG)
    ) fwd_y (
        .raddr   (RY),
        .reg_data(regs[RY]),
        .wen0    (WEN0),
        .waddr0  (RW0),
        .wdata0  (busW0),
        .wen1    (WEN1),
        .waddr1  (RW1),
        .wdata1  (busW1),
        .suppress(restore),
        .rdata   (busY)
    );

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file: successor to the 8x8 single-write `register_file`. Adds a second write port with fixed priority, optional write-through bypass to both read ports, synchronous active-low clear, and a one-deep checkpoint/restore shadow bank. Sits in the datapath as the architectural register store, read combinationally in decode and written back at the clock edge.

## Interface
Parameters:
- DATA_W, 8, register and bus width
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads show pre-edge contents
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes

Ports:
- Clk  in  1  clock, all state updates on posedge
- Rst_n  in  1  synchronous, active-low reset
- WEN0  in  1  write enable, port 0
- RW0  in  ADDR_W  write address, port 0
- busW0  in  DATA_W  write data, port 0
- WEN1  in  1  write enable, port 1 (priority port)
- RW1  in  ADDR_W  write address, port 1
- busW1  in  DATA_W  write data, port 1
- RX  in  ADDR_W  read address X
- RY  in  ADDR_W  read address Y
- busX  out  DATA_W  read data X, combinational
- busY  out  DATA_W  read data Y, combinational
- CKPT  in  1  checkpoint request
- RSTR  in  1  restore request
- CkptV  out  1  registered; 1 = shadow bank holds a valid checkpoint

## Operation
- Reset: Rst_n low at posedge clears all DEPTH registers, all shadow entries, and CkptV to 0. Reset overrides every other input that cycle. After reset busX = busY = 0 for any address.
- Write: at posedge, port k writes busWk to reg[RWk] when WENk=1. With ZERO_REG=1, writes to address 0 are dropped.
- Collision: WEN0=WEN1=1 and RW0==RW1 → port 1 data stored; port 0 discarded.
- Read: busX = reg[RX], busY = reg[RY], combinational. ZERO_REG=1 and address 0 → 0, regardless of bypass.
- Bypass (BYPASS=1): if WEN1 and RW1==RX, busX = busW1; else if WEN0 and RW0==RX, busX = busW0; else reg[RX]. Same rule for busY/RY. Suppressed while a restore is taking effect (RSTR=1 and CkptV=1). With BYPASS=0, new data is visible only after the edge.
- Checkpoint: CKPT=1 at posedge copies pre-edge register contents into the shadow bank (writes of that same cycle are not captured) and sets CkptV=1. A new CKPT overwrites the old checkpoint.
- Restore: RSTR=1 and CkptV=1 at posedge loads every register from the shadow bank. Writes in that cycle are dropped. CkptV stays 1, so repeated restores are allowed.
- RSTR=1 with CkptV=0: restore is ignored, and writes and bypass proceed normally.
- CKPT and RSTR in the same cycle (CkptV=1): restore takes effect and the shadow bank is unchanged.

## Timing
- Write-to-read latency: 0 cycles with BYPASS=1 (same cycle); 1 edge with BYPASS=0.
- CKPT to CkptV=1: visible after the same posedge.
- RSTR: restored values visible on busX/busY immediately after the edge.
- No handshakes. Every request is single-cycle and accepted unconditionally except as stated above.
- Inputs must be stable around the posedge. The read path is purely combinational from RX/RY/W-ports to busX/busY.

## Structure
- Shared package `regfile_pkg` holds the default DATA_W/ADDR_W constants and a `rf_word_t` typedef for DATA_W-wide words.
- One natural sub-module is `regfile_fwd`: the per-read-port bypass/zero mux, instantiated twice, once for X and once for Y.
- Main arrays `regs[DEPTH]` and `shadow[DEPTH]` plus the CkptV flop live in the top module.

## Test plan
- Reset then write sweep (defaults): reset, then write reg i = 8'hA0+i via port 0, one per cycle, and read back on RX and RY → busX = busY = A0+i for i=1..7. Reg 0 reads 00 after writing A0.
- Dual-write collision: WEN0=WEN1=1, RW0=RW1=3, busW0=11, busW1=22 → same-cycle busX(RX=3) = 22 and reg3 = 22 after the edge. Different addresses 2/5 → both stored.
- Bypass modes: with BYPASS=1, write reg4=5A and RX=4 in the same cycle → busX = 5A before the edge. Rebuild with BYPASS=0 → old value before the edge, 5A after.
- Checkpoint/restore: reg1=01, CKPT while writing reg1=FF, then write reg1=77, RSTR → reg1=01 and CkptV=1. A write to reg2 in the RSTR cycle is dropped.
- Restore without checkpoint: after reset, RSTR with write reg6=3C → ignored, reg6=3C, CkptV=0.
- Mid-operation reset: Rst_n=0 together with CKPT, writes, and RSTR → all registers 00, CkptV=0. A following RSTR has no effect.
